// File: rtl/maxpool_pkg.sv
`default_nettype none
// ============================================================================
// Module      : maxpool_pkg
// Description : Shared types, default sizing and element compare helper for
//               the streaming 2x2 / stride-2 max-pool engine.
// Revision    : 1.0 - initial release
// ============================================================================
package maxpool_pkg;

    // Frame sequencing: IDLE waits for start, EVEN fills the line buffer,
    // ODD pools against it, DRAIN waits for the last pooled beat to leave.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVEN  = 2'd1,
        ODD   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // Default geometry of the engine.
    localparam int DEF_BITS  = 8;
    localparam int DEF_LANES = 4;
    localparam int WORD      = DEF_BITS * DEF_LANES;
    localparam int OWORD     = WORD / 2;

    // Widest element the compare helper handles.
    localparam int MAX2_W    = 32;

    // Element compare: returns 1 when a >= b, so the caller keeps a.
    // Operands are zero-extended elements of 'bits' width. For a signed
    // compare, flipping the element sign bit maps two's-complement order
    // onto unsigned order, which lets one magnitude comparator serve both.
    function automatic logic max2(
        input logic [MAX2_W-1:0] a,
        input logic [MAX2_W-1:0] b,
        input int unsigned       bits,
        input logic              is_signed
    );
        logic [MAX2_W-1:0] flip;
        logic [MAX2_W-1:0] ka;
        logic [MAX2_W-1:0] kb;
        flip = is_signed ? (MAX2_W'(1) << (bits - 1)) : '0;
        ka   = a ^ flip;
        kb   = b ^ flip;
        return (ka >= kb);
    endfunction

endpackage : maxpool_pkg
`default_nettype wire

// File: rtl/maxpool_max4.sv
`default_nettype none
// ============================================================================
// Module      : maxpool_max4
// Description : Combinational maximum of four elements (one 2x2 window).
// Revision    : 1.0 - initial release
// ============================================================================
module maxpool_max4
    import maxpool_pkg::*;
#(
    parameter int BITS   = 8,
    parameter int SIGNED = 0
) (
    input  logic [BITS-1:0] a_i,
    input  logic [BITS-1:0] b_i,
    input  logic [BITS-1:0] c_i,
    input  logic [BITS-1:0] d_i,
    output logic [BITS-1:0] y_o
);

    logic [BITS-1:0] w_ab;
    logic [BITS-1:0] w_cd;

    // Two-level tree: pair maxima first, then the winner of the pairs.
    always_comb begin
        w_ab = max2(MAX2_W'(a_i), MAX2_W'(b_i), BITS, SIGNED != 0) ? a_i : b_i;
        w_cd = max2(MAX2_W'(c_i), MAX2_W'(d_i), BITS, SIGNED != 0) ? c_i : d_i;
        y_o  = max2(MAX2_W'(w_ab), MAX2_W'(w_cd), BITS, SIGNED != 0) ? w_ab : w_cd;
    end

endmodule : maxpool_max4
`default_nettype wire

// File: rtl/maxpool_stream.sv
`default_nettype none
// ============================================================================
// Module      : maxpool_stream
// Description : Streaming 2x2, stride-2 max-pool. Even rows are parked in a
//               single-row line buffer; each odd-row word is pooled against
//               the buffered word above it and emitted as a half-width word.
// Revision    : 1.0 - initial release
// ============================================================================
module maxpool_stream
    import maxpool_pkg::*;
#(
    parameter int BITS   = DEF_BITS,
    parameter int LANES  = DEF_LANES,
    parameter int MAX_W  = 32,
    parameter int SIGNED = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [$clog2(MAX_W+1)-1:0]     width,
    input  logic [15:0]                    height,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [BITS*LANES-1:0]          in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [BITS*LANES/2-1:0]        out_data,
    output logic                           busy,
    output logic                           done,
    output logic                           err
);

    localparam int WORD_W  = BITS * LANES;
    localparam int OWORD_W = WORD_W / 2;
    localparam int WPR     = MAX_W / LANES;               // words per row, max
    localparam int CW      = (WPR > 1) ? $clog2(WPR) : 1;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    state_t               state_q;
    logic [CW-1:0]        col_q;
    logic [CW-1:0]        last_col_q;
    logic [15:0]          row_q;
    logic [15:0]          height_q;
    logic                 out_valid_q;
    logic [OWORD_W-1:0]   out_data_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 err_q;
    logic [WORD_W-1:0]    linebuf_q [WPR];

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic                 w_in_ready;
    logic                 w_in_fire;
    logic                 w_out_fire;
    logic                 w_row_end;
    logic                 w_cfg_ok;
    logic [CW-1:0]        w_last_col;
    logic [CW-1:0]        col_d;
    logic [15:0]          row_d;
    logic [WORD_W-1:0]    w_buf_word;
    logic [OWORD_W-1:0]   w_pooled;

    // Input acceptance by state; in ODD a stalled result blocks new words
    // unless it is leaving this very cycle.
    always_comb begin
        w_in_ready = 1'b0;
        unique case (state_q)
            EVEN:    w_in_ready = 1'b1;
            ODD:     w_in_ready = !out_valid_q || out_ready;
            default: w_in_ready = 1'b0;
        endcase
    end

    assign w_in_fire  = in_valid && w_in_ready;
    assign w_out_fire = out_valid_q && out_ready;
    assign w_row_end  = (col_q == last_col_q);
    assign col_d      = col_q + 1'b1;
    assign row_d      = row_q + 16'd2;
    assign w_buf_word = linebuf_q[col_q];

    // Frame configuration check and the last word index of a row.
    assign w_cfg_ok   = (width != '0)
                     && (32'(width) <= MAX_W)
                     && ((32'(width) % LANES) == 0)
                     && (height != 16'd0)
                     && !height[0];
    assign w_last_col = CW'((32'(width) / LANES) - 1);

    // ------------------------------------------------------------------------
    // One 2x2 window per output lane: lanes 2k/2k+1 of the incoming word and
    // of the buffered word directly above it.
    // ------------------------------------------------------------------------
    for (genvar k = 0; k < LANES/2; k++) begin : g_lane
        maxpool_max4 #(
            .BITS   (BITS),
            .SIGNED (SIGNED)
        ) u_max4 (
            .a_i (in_data   [WORD_W-1-(2*k)*BITS   -: BITS]),
            .b_i (in_data   [WORD_W-1-(2*k+1)*BITS -: BITS]),
            .c_i (w_buf_word[WORD_W-1-(2*k)*BITS   -: BITS]),
            .d_i (w_buf_word[WORD_W-1-(2*k+1)*BITS -: BITS]),
            .y_o (w_pooled  [OWORD_W-1-k*BITS      -: BITS])
        );
    end

    // Line buffer: captures the even row; contents are don't-care at reset.
    always_ff @(posedge clk) begin
        if (state_q == EVEN && w_in_fire) begin
            linebuf_q[col_q] <= in_data;
        end
    end

    // Frame sequencer with registered output stage and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            col_q       <= '0;
            last_col_q  <= '0;
            row_q       <= 16'd0;
            height_q    <= 16'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;

            // Output stage: a new pooled word overrides the retire of the
            // previous one, so back-to-back results carry no bubble.
            if (w_out_fire) begin
                out_valid_q <= 1'b0;
            end
            if (state_q == ODD && w_in_fire) begin
                out_valid_q <= 1'b1;
                out_data_q  <= w_pooled;
            end

            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        if (w_cfg_ok) begin
                            height_q   <= height;
                            last_col_q <= w_last_col;
                            col_q      <= '0;
                            row_q      <= 16'd0;
                            busy_q     <= 1'b1;
                            state_q    <= EVEN;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                EVEN: begin
                    if (w_in_fire) begin
                        if (w_row_end) begin
                            col_q   <= '0;
                            state_q <= ODD;
                        end else begin
                            col_q <= col_d;
                        end
                    end
                end
                ODD: begin
                    if (w_in_fire) begin
                        if (w_row_end) begin
                            col_q   <= '0;
                            row_q   <= row_d;
                            state_q <= (row_d == height_q) ? DRAIN : EVEN;
                        end else begin
                            col_q <= col_d;
                        end
                    end
                end
                DRAIN: begin
                    if (!out_valid_q || w_out_fire) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule : maxpool_stream
`default_nettype wire

// File: tb/tb_maxpool_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_maxpool_stream
// Description : Self-checking bench for maxpool_stream. An unsigned and a
//               signed instance share all inputs; results are compared with
//               constant vectors and with a 2-D image pooling model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_maxpool_stream;

    localparam int BITS  = 8;
    localparam int LANES = 4;
    localparam int MAX_W = 32;
    localparam int WW    = $clog2(MAX_W+1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [WW-1:0]     width = '0;
    logic [15:0]       height = 16'd0;
    logic              in_valid = 1'b0;
    logic [31:0]       in_data = 32'd0;
    logic              out_ready = 1'b0;

    logic              in_ready_u, out_valid_u, busy_u, done_u, err_u;
    logic [15:0]       out_data_u;
    logic              in_ready_s, out_valid_s, busy_s, done_s, err_s;
    logic [15:0]       out_data_s;

    always #5 clk = ~clk;

    maxpool_stream #(.BITS(BITS), .LANES(LANES), .MAX_W(MAX_W), .SIGNED(0)) dut_u (
        .clk(clk), .rst_n(rst_n), .start(start), .width(width), .height(height),
        .in_valid(in_valid), .in_ready(in_ready_u), .in_data(in_data),
        .out_valid(out_valid_u), .out_ready(out_ready), .out_data(out_data_u),
        .busy(busy_u), .done(done_u), .err(err_u)
    );

    maxpool_stream #(.BITS(BITS), .LANES(LANES), .MAX_W(MAX_W), .SIGNED(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start), .width(width), .height(height),
        .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
        .busy(busy_s), .done(done_s), .err(err_s)
    );

    int          tests = 0;
    int          fails = 0;
    logic [15:0] q_u[$];
    logic [15:0] q_s[$];
    int          done_u_cnt = 0, done_s_cnt = 0, err_u_cnt = 0, err_s_cnt = 0;
    int          rdy_mode = 0;           // 0: always ready, 1: toggle, 2: random
    logic [7:0]  pix [0:15][0:31];       // frame image, row/column of elements

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Output monitor: samples at the falling edge, where the handshake for the
    // coming rising edge is already settled.
    logic        stall_u = 1'b0, stall_s = 1'b0;
    logic [15:0] held_u = 16'd0, held_s = 16'd0;
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_u = 1'b0;
            stall_s = 1'b0;
        end else begin
            if (stall_u) begin
                check("hold_valid_u", {31'd0, out_valid_u}, 32'd1);
                check("hold_data_u", {16'd0, out_data_u}, {16'd0, held_u});
            end
            if (stall_s) begin
                check("hold_valid_s", {31'd0, out_valid_s}, 32'd1);
                check("hold_data_s", {16'd0, out_data_s}, {16'd0, held_s});
            end
            if (out_valid_u && out_ready) q_u.push_back(out_data_u);
            if (out_valid_s && out_ready) q_s.push_back(out_data_s);
            stall_u = out_valid_u && !out_ready;
            stall_s = out_valid_s && !out_ready;
            held_u  = out_data_u;
            held_s  = out_data_s;
            if (done_u) done_u_cnt++;
            if (done_s) done_s_cnt++;
            if (err_u)  err_u_cnt++;
            if (err_s)  err_s_cnt++;
        end
    end

    // Downstream readiness pattern.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Reference: max over each 2x2 block of the image, signed or unsigned.
    function automatic logic [15:0] model_word(input int orow, input int ow, input bit sgn);
        logic [15:0] r;
        logic [7:0]  p;
        logic [7:0]  bestv;
        int          best, v, pc;
        r = 16'd0;
        for (int k = 0; k < 2; k++) begin
            pc    = ow * 2 + k;
            best  = -1000;
            bestv = 8'd0;
            for (int dy = 0; dy < 2; dy++) begin
                for (int dx = 0; dx < 2; dx++) begin
                    p = pix[2*orow+dy][2*pc+dx];
                    v = sgn ? int'($signed(p)) : int'(p);
                    if (v > best) begin
                        best  = v;
                        bestv = p;
                    end
                end
            end
            r[15-8*k -: 8] = bestv;
        end
        return r;
    endfunction

    function automatic logic [31:0] pix_word(input int row, input int j);
        return {pix[row][4*j], pix[row][4*j+1], pix[row][4*j+2], pix[row][4*j+3]};
    endfunction

    task automatic load_word(input int row, input int j, input logic [31:0] d);
        for (int e = 0; e < 4; e++) pix[row][4*j+e] = d[31-8*e -: 8];
    endtask

    task automatic fill_random(input int w, input int h);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++) pix[r][c] = 8'($urandom_range(0, 255));
    endtask

    // All driver tasks enter and leave 1 time unit after a rising edge.
    task automatic do_start(input int w, input int h);
        start  = 1'b1;
        width  = WW'(w);
        height = 16'(h);
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d);
        int n;
        bit acc;
        n        = 0;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready_u;
            @(posedge clk); #1;
            if (!acc) begin
                n++;
                if (n > 200) begin
                    tests++;
                    fails++;
                    $display("FAIL in_ready_timeout: got 0, expected 1 within 200 cycles");
                    break;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    // Sends the image held in pix and waits for done; optionally checks the
    // produced beats against the model.
    task automatic run_frame(input int w, input int h, input bit use_model, input bit gaps,
                             input logic [31:0] alt_w);
        int d0, d1, n, wpr;
        d0  = done_u_cnt;
        d1  = done_s_cnt;
        wpr = w / 4;
        q_u.delete();
        q_s.delete();
        do_start(w, h);
        check("busy_after_start", {30'd0, busy_u, busy_s}, 32'd3);
        for (int r = 0; r < h; r++) begin
            for (int j = 0; j < wpr; j++) begin
                send_word(pix_word(r, j));
                if (gaps && ($urandom_range(0, 3) == 0)) begin
                    @(posedge clk); #1;
                end
                if (alt_w != 0 && r == 0 && j == 0) begin
                    do_start(int'(alt_w), 2);   // must be ignored mid-frame
                end
            end
        end
        n = 0;
        while ((done_u_cnt == d0 || done_s_cnt == d1) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("done_pulse_u", done_u_cnt - d0, 1);
        check("done_pulse_s", done_s_cnt - d1, 1);
        check("busy_after_done", {30'd0, busy_u, busy_s}, 32'd0);
        check("beats_u", q_u.size(), (h / 2) * wpr);
        check("beats_s", q_s.size(), (h / 2) * wpr);
        if (use_model) begin
            for (int i = 0; i < q_u.size() && i < (h / 2) * wpr; i++)
                check("model_u", {16'd0, q_u[i]}, {16'd0, model_word(i / wpr, i % wpr, 1'b0)});
            for (int i = 0; i < q_s.size() && i < (h / 2) * wpr; i++)
                check("model_s", {16'd0, q_s[i]}, {16'd0, model_word(i / wpr, i % wpr, 1'b1)});
        end
    endtask

    typedef struct packed {
        logic [31:0] r0;
        logic [31:0] r1;
        logic [15:0] eu;
        logic [15:0] es;
    } vec_t;

    typedef struct packed {
        logic [7:0]  w;
        logic [15:0] h;
    } bad_t;

    vec_t vecs [4];
    bad_t bads [5];

    initial begin
        int e0, e1, ew, eh;
        vecs[0] = '{r0: 32'h01020304, r1: 32'h05000008, eu: 16'h0508, es: 16'h0508};
        vecs[1] = '{r0: 32'hFF01FF01, r1: 32'hFEFEFEFE, eu: 16'hFFFF, es: 16'h0101};
        vecs[2] = '{r0: 32'h807F0010, r1: 32'h8101FF20, eu: 16'h81FF, es: 16'h7F20};
        vecs[3] = '{r0: 32'h55555555, r1: 32'h55555555, eu: 16'h5555, es: 16'h5555};
        bads[0] = '{w: 8'd6,  h: 16'd2};
        bads[1] = '{w: 8'd4,  h: 16'd3};
        bads[2] = '{w: 8'd0,  h: 16'd2};
        bads[3] = '{w: 8'd36, h: 16'd2};
        bads[4] = '{w: 8'd4,  h: 16'd0};

        // Reset state
        #3;
        check("rst_in_ready", {30'd0, in_ready_u, in_ready_s}, 32'd0);
        check("rst_out_valid", {30'd0, out_valid_u, out_valid_s}, 32'd0);
        check("rst_out_data", {out_data_u, out_data_s}, 32'd0);
        check("rst_flags", {26'd0, busy_u, busy_s, done_u, done_s, err_u, err_s}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Constant 4x2 frames
        rdy_mode = 0;
        for (int i = 0; i < 4; i++) begin
            load_word(0, 0, vecs[i].r0);
            load_word(1, 0, vecs[i].r1);
            run_frame(4, 2, 1'b0, 1'b0, 32'd0);
            if (q_u.size() == 1) check("vec_u", {16'd0, q_u[0]}, {16'd0, vecs[i].eu});
            if (q_s.size() == 1) check("vec_s", {16'd0, q_s[0]}, {16'd0, vecs[i].es});
        end

        // Illegal configurations
        for (int i = 0; i < 5; i++) begin
            e0 = err_u_cnt;
            e1 = err_s_cnt;
            ew = int'(bads[i].w);
            eh = int'(bads[i].h);
            do_start(ew, eh);
            check("err_pulse", {30'd0, err_u, err_s}, 32'd3);
            check("err_busy_ready", {28'd0, busy_u, busy_s, in_ready_u, in_ready_s}, 32'd0);
            @(posedge clk); #1;
            check("err_one_cycle", {30'd0, err_u, err_s}, 32'd0);
            check("err_count", (err_u_cnt - e0) + (err_s_cnt - e1), 2);
        end

        // 8x4 random frame with alternating backpressure
        rdy_mode = 1;
        fill_random(8, 4);
        run_frame(8, 4, 1'b1, 1'b0, 32'd0);

        // Start while busy, narrower width requested
        rdy_mode = 0;
        e0 = err_u_cnt;
        fill_random(8, 2);
        run_frame(8, 2, 1'b1, 1'b0, 32'd4);
        check("busy_start_no_err", err_u_cnt - e0, 0);

        // Reset during the second odd-row word
        fill_random(8, 4);
        do_start(8, 4);
        send_word(pix_word(0, 0));
        send_word(pix_word(0, 1));
        send_word(pix_word(1, 0));
        in_valid = 1'b1;
        in_data  = pix_word(1, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", {30'd0, in_ready_u, in_ready_s}, 32'd0);
        check("mid_rst_valid", {30'd0, out_valid_u, out_valid_s}, 32'd0);
        check("mid_rst_data", {out_data_u, out_data_s}, 32'd0);
        check("mid_rst_flags", {26'd0, busy_u, busy_s, done_u, done_s, err_u, err_s}, 32'd0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        fill_random(16, 6);
        run_frame(16, 6, 1'b1, 1'b1, 32'd0);

        // Random legal frames with random backpressure and input gaps
        rdy_mode = 2;
        for (int f = 0; f < 6; f++) begin
            ew = 4 * int'($urandom_range(1, 8));
            eh = 2 * int'($urandom_range(1, 4));
            fill_random(ew, eh);
            run_frame(ew, eh, 1'b1, 1'b1, 32'd0);
        end

        rdy_mode = 0;
        @(posedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global guard against a hung run.
    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected completion before 500000 time units");
        $fatal(1);
    end

endmodule : tb_maxpool_stream
`default_nettype wire

// File: doc/maxpool_stream.md
# maxpool_stream

Streaming 2×2, stride-2 max-pool engine for the accelerator datapath. Packed pixel words arrive row-major over a valid/ready input stream, and pooled words leave over a valid/ready output stream. Element width, lanes per word, maximum row width and signedness are parameters; frame dimensions are set at run time. A single-row line buffer replaces full-frame storage, so any frame height up to 2^16−2 is supported.

## Interface
- BITS, 8, element width in bits
- LANES, 4, elements per input word (even, ≥2); WORD = BITS*LANES
- MAX_W, 32, maximum row width in elements (multiple of LANES)
- SIGNED, 0, 1 = two's-complement compare, 0 = unsigned compare
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; latches width/height when IDLE
- width  in  $clog2(MAX_W+1)  row width in elements
- height  in  16  frame height in rows
- in_valid  in  1  input word valid
- in_ready  out  1  input word accepted when in_valid&in_ready
- in_data  in  WORD  lanes packed MSB-first (lane 0 = [WORD-1 -: BITS] = leftmost pixel)
- out_valid  out  1  pooled word valid
- out_ready  in  1  downstream accepts when out_valid&out_ready
- out_data  out  WORD/2  LANES/2 pooled elements, lane 0 at MSB
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after the last output beat is accepted
- err  out  1  one-cycle pulse on an illegal start

## Operation
- States: IDLE, EVEN, ODD, DRAIN.
- IDLE: in_ready=0. On start, validate the configuration. It is legal when width≠0, width≤MAX_W, width%LANES==0, height≠0 and height is even. If legal, latch the configuration and go to EVEN with col=0 and row=0; busy=1. If illegal, pulse err the next cycle and stay IDLE.
- start is ignored outside IDLE.
- EVEN: in_ready=1. Each accepted word is written to linebuf[col], and col increments. When col reaches width/LANES−1 and a word is accepted, set col=0 and go to ODD.
- ODD: in_ready = !out_valid || out_ready. For an accepted word w and buffered word b = linebuf[col], pooled lane k = max(w[2k], w[2k+1], b[2k], b[2k+1]). The compare is signed when SIGNED=1.
- The pooled word is registered into out_data, and out_valid is set.
- At end of row: row += 2. If row == height, go to DRAIN; otherwise go to EVEN.
- DRAIN: in_ready=0. When out_valid is clear or is accepted this cycle, pulse done, clear busy and go to IDLE.
- Equal elements are not an error; any of the equal values is output.
- Counters: col is $clog2(MAX_W/LANES) bits and wraps to 0 at each row end; row is 16 bits.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, busy=0, done=0, err=0; state=IDLE; linebuf contents don't-care.
- busy rises the cycle after a legal start, and the first word is accepted that cycle at the earliest.
- Output latency: out_valid rises 1 cycle after the ODD-row word is accepted.
- Sustained throughput: 1 input word per cycle in EVEN and ODD when out_ready=1. Output produces 1 word per 2 input words.
- Output holding: out_data and out_valid are held stable while out_valid&!out_ready.
- Simultaneous accept: an output accept and a new ODD input accept in the same cycle replace out_data without a bubble.
- done rises the cycle after the final output handshake. If the final output is accepted in the same cycle it is produced, done pulses the next cycle.
- Asynchronous reset mid-frame aborts the frame. All outputs return to reset values, and partial data is discarded.
- No output is produced for a frame with no ODD rows; that case cannot occur because height≥2 is enforced.

## Structure
- Package maxpool_pkg:
  - state enum (IDLE/EVEN/ODD/DRAIN)
  - parameterised compare function max2 (signed/unsigned)
  - localparams WORD and OWORD = WORD/2
- Sub-module maxpool_max4: combinational 4-input max, parameters BITS and SIGNED. Instantiate LANES/2 copies in a generate loop.
- Line buffer: MAX_W/LANES × WORD flops, with no reset.

## Test plan
- Basic frame (LANES=4, BITS=8, width=4, height=2): row0 0x01020304, row1 0x05000008 -> one beat out_data=0x0508, then done pulse; busy low afterwards.
- Signedness: row0 0xFF01FF01, row1 0xFEFEFEFE. With SIGNED=0 -> out_data=0xFFFF. With SIGNED=1 -> out_data=0x0101.
- Multi-row frame with backpressure: width=8, height=4, out_ready toggling 1010…, random data -> 4 beats matching the reference model in order; out_data stable while stalled; no lost or duplicated beats.
- Illegal start: width=6 (not a multiple of 4), height=3, or width=0 -> err pulse, busy stays 0, in_ready stays 0.
- Reset mid-frame: assert rst_n low during the second ODD word -> all outputs at reset values. A subsequent legal frame produces correct results.
- Start while busy: pulse start in EVEN with different width -> ignored; the frame completes with the original dimensions.
